// File: rtl/nios2_secure_memory_protected_ram_if.sv
// Avalon-MM slave bundle used for the s1 (trusted) and s2 (untrusted) ports.
// Handshake: an access is accepted in a cycle where
// chipselect & (read | write) & ~waitrequest; readdatavalid qualifies
// readdata exactly one cycle after an accepted read.
interface nios2_secure_memory_protected_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nios2_secure_memory_protected_ram.sv
// Dual-port secure RAM: s1 trusted, s2 blocked from one programmable window,
// hardware zeroize engine, optional per-byte even parity.
// Optional feature macro: SECURE_MEM_PARITY_EN (per-byte parity storage/check).
module nios2_secure_memory_protected_ram #(
    parameter int    DATA_WIDTH       = 32,
    parameter int    ADDR_WIDTH       = 13,
    parameter int    DEPTH            = 5120,
    parameter int    ZEROIZE_ON_RESET = 1,
    parameter string INIT_FILE        = "nios2_secure_memory_onchip_mem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    nios2_secure_memory_protected_ram_if.slave s1,
    nios2_secure_memory_protected_ram_if.slave s2,
    input  logic [1:0]  ctrl_address,
    input  logic        ctrl_write,
    input  logic        ctrl_read,
    input  logic [31:0] ctrl_writedata,
    output logic [31:0] ctrl_readdata,
    output logic        parity_error,
    output logic        violation_irq,
    output logic        dbg_state
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // The preload image is applied by the device memory-initialisation flow.
    localparam string unused_init_file = INIT_FILE;

    typedef enum logic {ST_IDLE = 1'b0, ST_SCRUB = 1'b1} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   scrub_addr_q;
    logic                    lock_en_q;
    logic [ADDR_WIDTH-1:0]   base_q, limit_q;
    logic                    viol_q, par_flag_q;
    logic [ADDR_WIDTH-1:0]   viol_addr_q;
    logic [DATA_WIDTH-1:0]   rd1_q, rd2_q;
    logic                    rdv1_q, rdv2_q, perr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic busy, s1_acc, s2_acc, s1_rd, s2_rd, s1_inr, s2_inr, s2_prot;
    logic s1_wr_ok, s2_wr_ok, s2_viol, ctrl_hit, zeroize_d, clr_d;
    logic p1_err_d, p2_err_d;
    logic [DATA_WIDTH-1:0] rd1_word, rd2_word;
    logic [31:0] ctrl_val;
    logic unused_ctrl_bits;

    assign busy      = (state_q == ST_SCRUB);
    assign s1_acc    = s1.chipselect & (s1.read | s1.write) & ~busy;
    assign s2_acc    = s2.chipselect & (s2.read | s2.write) & ~busy;
    assign s1_rd     = s1_acc & s1.read;
    assign s2_rd     = s2_acc & s2.read;
    assign s1_inr    = ({1'b0, s1.address} < DEPTH_W);
    assign s2_inr    = ({1'b0, s2.address} < DEPTH_W);
    // An inverted window (base > limit) matches nothing by construction.
    assign s2_prot   = lock_en_q & (s2.address >= base_q) & (s2.address <= limit_q);
    assign s2_viol   = s2_acc & s2_inr & s2_prot;
    assign s1_wr_ok  = s1_acc & s1.write & s1_inr;
    // s1 owns a shared address outright; the s2 write is silently dropped.
    assign s2_wr_ok  = s2_acc & s2.write & s2_inr & ~s2_prot
                     & ~(s1_wr_ok & (s1.address == s2.address));
    assign ctrl_hit  = ctrl_write & (ctrl_address == 2'd0);
    assign zeroize_d = ctrl_hit & ctrl_writedata[1] & ~busy;
    assign clr_d     = ctrl_hit & ctrl_writedata[2];
    assign rd1_word  = mem_q[s1.address];
    assign rd2_word  = mem_q[s2.address];
    assign unused_ctrl_bits = ^ctrl_writedata[31:ADDR_WIDTH];

    // Data array: scrub has exclusive use of port A while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[scrub_addr_q] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (s2_wr_ok && s2.byteenable[b]) mem_q[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
                if (s1_wr_ok && s1.byteenable[b]) mem_q[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
            end
        end
    end

`ifdef SECURE_MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] rd1_par, rd2_par;
    logic          p1_mis, p2_mis;
    assign rd1_par = par_q[s1.address];
    assign rd2_par = par_q[s2.address];

    // Parity storage follows the data array lane by lane; zero has even parity 0.
    always_ff @(posedge clk) begin
        if (busy) begin
            par_q[scrub_addr_q] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (s2_wr_ok && s2.byteenable[b]) par_q[s2.address][b] <= ^s2.writedata[b*8 +: 8];
                if (s1_wr_ok && s1.byteenable[b]) par_q[s1.address][b] <= ^s1.writedata[b*8 +: 8];
            end
        end
    end

    // Recompute parity of the word being read and compare to the stored bits.
    always_comb begin
        p1_mis = 1'b0;
        p2_mis = 1'b0;
        for (int b = 0; b < NB; b++) begin
            p1_mis = p1_mis | ((^rd1_word[b*8 +: 8]) ^ rd1_par[b]);
            p2_mis = p2_mis | ((^rd2_word[b*8 +: 8]) ^ rd2_par[b]);
        end
    end
    assign p1_err_d = s1_rd & s1_inr & p1_mis;
    assign p2_err_d = s2_rd & s2_inr & ~s2_prot & p2_mis;
`else
    assign p1_err_d = 1'b0;
    assign p2_err_d = 1'b0;
`endif

    // Zeroize FSM: one word per clock from 0 to DEPTH-1, then back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= (ZEROIZE_ON_RESET != 0) ? ST_SCRUB : ST_IDLE;
            scrub_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (zeroize_d) begin
                        state_q      <= ST_SCRUB;
                        scrub_addr_q <= '0;
                    end
                end
                default: begin
                    if (scrub_addr_q == LAST_ADDR) begin
                        state_q      <= ST_IDLE;
                        scrub_addr_q <= '0;
                    end else begin
                        scrub_addr_q <= scrub_addr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Control registers; the window survives zeroize.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_en_q <= 1'b0;
            base_q    <= '0;
            limit_q   <= '0;
        end else if (ctrl_write) begin
            case (ctrl_address)
                2'd0:    lock_en_q <= ctrl_writedata[0];
                2'd1:    base_q    <= ctrl_writedata[ADDR_WIDTH-1:0];
                2'd2:    limit_q   <= ctrl_writedata[ADDR_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Sticky status flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            viol_q      <= 1'b0;
            viol_addr_q <= '0;
            par_flag_q  <= 1'b0;
        end else begin
            if (s2_viol) begin
                viol_q <= 1'b1;
                if (!viol_q) viol_addr_q <= s2.address;
            end else if (clr_d) begin
                viol_q <= 1'b0;
            end
            if (p1_err_d || p2_err_d) par_flag_q <= 1'b1;
            else if (clr_d)           par_flag_q <= 1'b0;
        end
    end

    // Read pipeline: one-cycle latency, old data on a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            rdv1_q <= 1'b0;
            rdv2_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            rdv1_q <= s1_rd;
            rdv2_q <= s2_rd;
            perr_q <= p1_err_d | p2_err_d;
            if (s1_rd) rd1_q <= s1_inr ? rd1_word : '0;
            if (s2_rd) rd2_q <= (s2_inr && !s2_prot) ? rd2_word : '0;
        end
    end

    // Control read mux, combinational and qualified by ctrl_read.
    always_comb begin
        ctrl_val = '0;
        case (ctrl_address)
            2'd0: ctrl_val[0] = lock_en_q;
            2'd1: ctrl_val[ADDR_WIDTH-1:0] = base_q;
            2'd2: ctrl_val[ADDR_WIDTH-1:0] = limit_q;
            default: begin
                ctrl_val[0] = busy;
                ctrl_val[1] = viol_q;
                ctrl_val[2] = par_flag_q;
                ctrl_val[16 +: ADDR_WIDTH] = viol_addr_q;
            end
        endcase
    end

    assign ctrl_readdata    = ctrl_read ? ctrl_val : 32'd0;
    assign s1.readdata      = rd1_q;
    assign s2.readdata      = rd2_q;
    assign s1.readdatavalid = rdv1_q;
    assign s2.readdatavalid = rdv2_q;
    assign s1.waitrequest   = busy;
    assign s2.waitrequest   = busy;
    assign parity_error     = perr_q;
    assign violation_irq    = viol_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_nios2_secure_memory_protected_ram.sv
// Randomised scoreboard bench for nios2_secure_memory_protected_ram.
module tb_nios2_secure_memory_protected_ram;
    localparam int DW = 32;
    localparam int AW = 13;
    localparam int DEPTH = 5120;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]  ctrl_address = '0;
    logic        ctrl_write = 1'b0, ctrl_read = 1'b0;
    logic [31:0] ctrl_writedata = '0;
    logic [31:0] ctrl_readdata;
    logic        parity_error, violation_irq, dbg_state;

    nios2_secure_memory_protected_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
    nios2_secure_memory_protected_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

    nios2_secure_memory_protected_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .ZEROIZE_ON_RESET(1)) dut (
        .clk(clk), .reset(reset), .s1(s1_if.slave), .s2(s2_if.slave),
        .ctrl_address(ctrl_address), .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
        .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata),
        .parity_error(parity_error), .violation_irq(violation_irq), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;

    // scoreboard queues
    logic [DW-1:0] exp1_q[$];
    logic [DW-1:0] exp2_q[$];
    int due1_q[$];
    int due2_q[$];
    int exp_perr_cyc = -1;

    // reference model
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_lock_en = 0;
    logic [AW-1:0] m_base = '0, m_limit = '0;
    bit            m_viol = 0;
    logic [AW-1:0] m_viol_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic bit in_window(input logic [AW-1:0] a);
        return m_lock_en && (m_base <= a) && (a <= m_limit);
    endfunction

    task automatic model_clear_mem();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // monitor: pops expected read data whenever a port presents readdatavalid
    always @(negedge clk) begin
        if (!reset) begin
            if (s1_if.readdatavalid) begin
                if (exp1_q.size() == 0) check("s1_unexpected_rdv", 32'd1, 32'd0);
                else begin
                    check("s1_rdata", s1_if.readdata, exp1_q.pop_front());
                    check("s1_latency", cyc, due1_q.pop_front());
                end
            end
            if (s2_if.readdatavalid) begin
                if (exp2_q.size() == 0) check("s2_unexpected_rdv", 32'd1, 32'd0);
                else begin
                    check("s2_rdata", s2_if.readdata, exp2_q.pop_front());
                    check("s2_latency", cyc, due2_q.pop_front());
                end
            end
            if (s1_if.readdatavalid || s2_if.readdatavalid || parity_error)
                check("parity_error", {31'd0, parity_error}, {31'd0, cyc == exp_perr_cyc});
        end
    end

    // driver: one bus cycle on s1, s2 and the control slave, model updated at the edge
    task automatic bus(input bit r1, input bit w1, input logic [AW-1:0] a1,
                       input logic [NB-1:0] be1, input logic [DW-1:0] d1,
                       input bit r2, input bit w2, input logic [AW-1:0] a2,
                       input logic [NB-1:0] be2, input logic [DW-1:0] d2,
                       input bit cw, input logic [1:0] ca, input logic [31:0] cd);
        bit in1, in2, prot2;
        @(negedge clk);
        s1_if.chipselect = r1 | w1; s1_if.read = r1; s1_if.write = w1;
        s1_if.address = a1; s1_if.byteenable = be1; s1_if.writedata = d1;
        s2_if.chipselect = r2 | w2; s2_if.read = r2; s2_if.write = w2;
        s2_if.address = a2; s2_if.byteenable = be2; s2_if.writedata = d2;
        ctrl_write = cw; ctrl_address = ca; ctrl_writedata = cd;
        if (r1 | w1 | r2 | w2) check("wait_idle", {31'd0, s1_if.waitrequest}, 32'd0);
        in1 = int'(a1) < DEPTH;
        in2 = int'(a2) < DEPTH;
        prot2 = in_window(a2);
        if (r1) begin exp1_q.push_back(in1 ? m_mem[a1] : '0); due1_q.push_back(cyc + 1); end
        if (r2) begin exp2_q.push_back((in2 && !prot2) ? m_mem[a2] : '0); due2_q.push_back(cyc + 1); end
        @(posedge clk);
        if ((r2 || w2) && in2 && prot2) begin
            if (!m_viol) m_viol_addr = a2;
            m_viol = 1;
        end else if (cw && ca == 2'd0 && cd[2]) begin
            m_viol = 0;
        end
        if (w2 && in2 && !prot2 && !(w1 && a1 == a2)) m_mem[a2] = merge(m_mem[a2], d2, be2);
        if (w1 && in1) m_mem[a1] = merge(m_mem[a1], d1, be1);
        if (cw) begin
            case (ca)
                2'd0: begin m_lock_en = cd[0]; if (cd[1]) model_clear_mem(); end
                2'd1: m_base = cd[AW-1:0];
                2'd2: m_limit = cd[AW-1:0];
                default: ;
            endcase
        end
        #1;
        s1_if.chipselect = 0; s1_if.read = 0; s1_if.write = 0;
        s2_if.chipselect = 0; s2_if.read = 0; s2_if.write = 0;
        ctrl_write = 0;
        check("violation_irq", {31'd0, violation_irq}, {31'd0, m_viol});
    endtask

    task automatic s1_wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        bus(0, 1, a, be, d, 0, 0, '0, '0, '0, 0, 2'd0, '0);
    endtask
    task automatic s1_rd(input logic [AW-1:0] a);
        bus(1, 0, a, '0, '0, 0, 0, '0, '0, '0, 0, 2'd0, '0);
    endtask
    task automatic s2_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus(0, 0, '0, '0, '0, 0, 1, a, '1, d, 0, 2'd0, '0);
    endtask
    task automatic s2_rd(input logic [AW-1:0] a);
        bus(0, 0, '0, '0, '0, 1, 0, a, '0, '0, 0, 2'd0, '0);
    endtask
    task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
        bus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, a, d);
    endtask
    task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctrl_address = a; ctrl_read = 1;
        #1 d = ctrl_readdata;
        ctrl_read = 0; ctrl_address = '0;
    endtask

    // counts busy cycles until waitrequest drops, bounded
    task automatic wait_scrub(input string name);
        int cnt = 0;
        while (s1_if.waitrequest && cnt < DEPTH + 100) begin
            @(posedge clk); #1; cnt++;
        end
        check(name, cnt, DEPTH);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(5116, 5123));
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        {s1_if.chipselect, s1_if.read, s1_if.write} = '0;
        {s2_if.chipselect, s2_if.read, s2_if.write} = '0;
        s1_if.address = '0; s1_if.byteenable = '0; s1_if.writedata = '0;
        s2_if.address = '0; s2_if.byteenable = '0; s2_if.writedata = '0;
        model_clear_mem();

        // reset values
        #12;
        check("rst_s1_rdv", {31'd0, s1_if.readdatavalid}, 32'd0);
        check("rst_s1_rdata", s1_if.readdata, 32'd0);
        check("rst_s2_rdata", s2_if.readdata, 32'd0);
        check("rst_wait", {30'd0, s1_if.waitrequest, s2_if.waitrequest}, 32'd3);
        check("rst_irq_perr", {30'd0, violation_irq, parity_error}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1 wait_scrub("scrub_len_reset");
        ctrl_rd(2'd3, st);
        check("status_idle", st, 32'd0);

        // post-scrub reads
        s1_rd(13'd0); s1_rd(13'd100); s1_rd(13'd5119);

        // basic data path and byte enables
        s1_wr(13'h10, 4'hF, 32'hDEADBEEF);
        s2_rd(13'h10);
        s1_wr(13'h10, 4'b0010, 32'h0000AA00);
        s1_rd(13'h10);
        s2_rd(13'h10);

        // out-of-range
        s1_wr(13'd5120, 4'hF, 32'h01020304);
        s1_rd(13'd5120);
        s2_rd(13'd5121);

        // protected window
        s1_wr(13'h15, 4'hF, 32'h5A5A0015);
        ctrl_wr(2'd1, 32'h10);
        ctrl_wr(2'd2, 32'h1F);
        ctrl_wr(2'd0, 32'h1);
        s2_wr(13'h15, 32'h12345678);
        s1_rd(13'h15);
        s2_rd(13'h15);
        ctrl_rd(2'd3, st);
        check("status_viol", st, {3'd0, 13'h15, 13'd0, 3'b010});
        s2_wr(13'h18, 32'hFFFFFFFF);
        ctrl_rd(2'd3, st);
        check("viol_addr_kept", {16'd0, st[31:16]}, 32'h15);
        ctrl_wr(2'd0, 32'h5);
        // window boundaries: just outside both ends is writable
        s2_wr(13'h0F, 32'hA000000F);
        s2_wr(13'h20, 32'hA0000020);
        s2_wr(13'h10, 32'hBAD00010);
        s2_rd(13'h0F); s2_rd(13'h20); s1_rd(13'h10); s2_rd(13'h1F);
        // clear in the same cycle as a new violation: violation wins
        bus(0, 0, '0, '0, '0, 0, 1, 13'h1F, 4'hF, 32'h1, 1, 2'd0, 32'h5);
        ctrl_wr(2'd0, 32'h5);

        // same-cycle writes
        bus(0, 1, 13'h20, 4'hF, 32'h11111111, 0, 1, 13'h20, 4'hF, 32'h22222222, 0, 2'd0, '0);
        s1_rd(13'h20);
        ctrl_rd(2'd3, st);
        check("status_same_addr", {31'd0, st[1]}, 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int op1, op2, cop;
            bit cw;
            logic [1:0] ca;
            logic [31:0] cd;
            op1 = $urandom_range(0, 2);
            op2 = $urandom_range(0, 2);
            cop = $urandom_range(0, 15);
            cw = (cop < 3);
            ca = 2'(cop);
            case (cop)
                0: cd = {29'd0, 1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom_range(0, 3) != 0)};
                1: cd = 32'($urandom_range(8, 24));
                2: cd = 32'($urandom_range(12, 48));
                default: cd = '0;
            endcase
            bus(op1 == 1, op1 == 2, rand_addr(), 4'($urandom_range(0, 15)), $urandom,
                op2 == 1, op2 == 2, rand_addr(), 4'($urandom_range(0, 15)), $urandom,
                cw, ca, cd);
        end
        ctrl_rd(2'd3, st);
        check("status_rand", {st[31:16], 14'd0, st[1:0]}, {3'd0, m_viol ? m_viol_addr : st[28:16], 14'd0, m_viol, 1'b0});

        // zeroize with a read accepted in the same cycle
        ctrl_wr(2'd1, 32'h10);
        ctrl_wr(2'd2, 32'h1F);
        ctrl_wr(2'd0, 32'h5);
        s1_wr(13'h40, 4'hF, 32'hCAFEF00D);
        bus(1, 0, 13'h40, '0, '0, 0, 0, '0, '0, '0, 1, 2'd0, 32'h3);
        wait_scrub("scrub_len_cmd");
        s1_rd(13'h40);
        s1_rd(13'h20);
        ctrl_rd(2'd1, st);
        check("base_kept", st, 32'h10);

        // reset in the middle of a scrub
        s1_wr(13'h40, 4'hF, 32'hA5A5A5A5);
        s1_rd(13'h40);
        s2_wr(13'h12, 32'h0);
        bus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1, 2'd0, 32'h3);
        repeat (50) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rdata", s1_if.readdata, 32'd0);
        check("mid_rst_rdv", {30'd0, s1_if.readdatavalid, s2_if.readdatavalid}, 32'd0);
        check("mid_rst_irq", {30'd0, violation_irq, parity_error}, 32'd0);
        check("mid_rst_wait", {30'd0, s1_if.waitrequest, s2_if.waitrequest}, 32'd3);
        m_lock_en = 0; m_base = '0; m_limit = '0; m_viol = 0; m_viol_addr = '0;
        ctrl_rd(2'd3, st);
        check("mid_rst_status", st, 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1 wait_scrub("scrub_len_rerst");
        s1_rd(13'h40);
        s2_rd(13'h12);

`ifdef SECURE_MEM_PARITY_EN
        s1_wr(13'h30, 4'hF, 32'h00000001);
        @(negedge clk);
        dut.par_q[48][0] = ~dut.par_q[48][0];
        exp_perr_cyc = cyc + 2;
        s1_rd(13'h30);
        ctrl_rd(2'd3, st);
        check("parity_flag", {31'd0, st[2]}, 32'd1);
`endif

        repeat (4) @(negedge clk);
        check("s1_pending", exp1_q.size(), 32'd0);
        check("s2_pending", exp2_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
